ad5674_spi_drv: RTL and testbench



---
 rtl/ad5674_spi_drv.sv | 145 ++++++++++++++
 tb/tb_ad5674_spi_drv.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad5674_spi_drv.sv
// ad5674_spi_drv: shifts one 24-bit AD5674 frame {cmd, addr, data} out on a
// shared SCLK/SDI pair and frames it with one of two SYNC lines, chosen by
// ch[4]. All serial outputs come straight from flops, so they are glitch-free.
module ad5674_spi_drv #(
  parameter int CLK_DIV  = 4,  // SCLK half-period in clk cycles
  parameter int CS_SETUP = 2,  // SYNC low to first bit phase
  parameter int CS_HOLD  = 2,  // last SCLK rise to SYNC high
  parameter int CS_GAP   = 4   // minimum SYNC-high time between frames
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ad5674_trig,
  input  logic [3:0]  ad5674_cmd,
  input  logic [4:0]  ad5674_ch,
  input  logic [15:0] ad5674_din,
  output logic        ad5674_busy,
  output logic        ad5674_done,
  output logic        ad5674_drop,
  output logic        ad5674_sclk,
  output logic        ad5674_sdi,
  output logic [1:0]  ad5674_sync_n
);

  // Half-period counter only has to reach CLK_DIV-1.
  localparam int HC_W = $clog2(CLK_DIV) + 1;

  // One shared wait counter covers the SETUP, HOLD and GAP phases.
  localparam int WAIT_MAX0 = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int WAIT_MAX  = (WAIT_MAX0 > CS_GAP) ? WAIT_MAX0 : CS_GAP;
  localparam int WC_W      = $clog2(WAIT_MAX + 1);

  localparam logic [HC_W-1:0] HC_ONE     = HC_W'(1);
  localparam logic [HC_W-1:0] HC_LAST    = HC_W'(CLK_DIV - 1);
  localparam logic [WC_W-1:0] WC_ONE     = WC_W'(1);
  localparam logic [WC_W-1:0] SETUP_LAST = WC_W'(CS_SETUP - 1);
  localparam logic [WC_W-1:0] HOLD_LAST  = WC_W'(CS_HOLD - 1);
  localparam logic [WC_W-1:0] GAP_LAST   = WC_W'(CS_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t            state_reg;
  logic [HC_W-1:0]   hcnt_reg;
  logic [WC_W-1:0]   wcnt_reg;
  logic [4:0]        bit_reg;
  logic [23:0]       shreg_reg;

  // Frame sequencer: every output is assigned here, so all are registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      hcnt_reg      <= '0;
      wcnt_reg      <= '0;
      bit_reg       <= '0;
      shreg_reg     <= '0;
      ad5674_busy   <= 1'b0;
      ad5674_done   <= 1'b0;
      ad5674_drop   <= 1'b0;
      ad5674_sclk   <= 1'b1;
      ad5674_sdi    <= 1'b0;
      ad5674_sync_n <= 2'b11;
    end else begin
      ad5674_done <= 1'b0;
      // Any trigger outside IDLE is rejected; the running frame carries on.
      ad5674_drop <= ad5674_trig && (state_reg != S_IDLE);

      case (state_reg)
        S_IDLE: begin
          if (ad5674_trig) begin
            shreg_reg     <= {ad5674_cmd, ad5674_ch[3:0], ad5674_din};
            ad5674_sync_n <= ad5674_ch[4] ? 2'b01 : 2'b10;
            ad5674_busy   <= 1'b1;
            wcnt_reg      <= '0;
            state_reg     <= S_SETUP;
          end
        end

        S_SETUP: begin
          if (wcnt_reg == SETUP_LAST) begin
            // Present bit 23 with SCLK high; first fall comes CLK_DIV later.
            ad5674_sdi <= shreg_reg[23];
            shreg_reg  <= {shreg_reg[22:0], 1'b0};
            bit_reg    <= 5'd23;
            hcnt_reg   <= '0;
            state_reg  <= S_SHIFT;
          end else begin
            wcnt_reg <= wcnt_reg + WC_ONE;
          end
        end

        S_SHIFT: begin
          if (hcnt_reg == HC_LAST) begin
            hcnt_reg <= '0;
            if (ad5674_sclk) begin
              ad5674_sclk <= 1'b0;
            end else if (bit_reg == 5'd0) begin
              // Final rising edge; SDI keeps bit 0 through HOLD.
              ad5674_sclk <= 1'b1;
              wcnt_reg    <= '0;
              state_reg   <= S_HOLD;
            end else begin
              ad5674_sclk <= 1'b1;
              ad5674_sdi  <= shreg_reg[23];
              shreg_reg   <= {shreg_reg[22:0], 1'b0};
              bit_reg     <= bit_reg - 5'd1;
            end
          end else begin
            hcnt_reg <= hcnt_reg + HC_ONE;
          end
        end

        S_HOLD: begin
          if (wcnt_reg == HOLD_LAST) begin
            ad5674_sync_n <= 2'b11;
            wcnt_reg      <= '0;
            state_reg     <= S_GAP;
          end else begin
            wcnt_reg <= wcnt_reg + WC_ONE;
          end
        end

        S_GAP: begin
          if (wcnt_reg == GAP_LAST) begin
            ad5674_busy <= 1'b0;
            ad5674_done <= 1'b1;
            ad5674_sdi  <= 1'b0;
            state_reg   <= S_IDLE;
          end else begin
            wcnt_reg <= wcnt_reg + WC_ONE;
          end
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ad5674_spi_drv.sv
// Testbench for ad5674_spi_drv: instance 0 uses default timing, instance 1
// the minimal timing (all 1). A cycle-based waveform model predicts every
// output each cycle; directed frames also pin literal expectations.
module tb_ad5674_spi_drv;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        trig   [2];
  logic [3:0]  cmd    [2];
  logic [4:0]  ch     [2];
  logic [15:0] din    [2];
  logic        busy   [2];
  logic        done   [2];
  logic        drop   [2];
  logic        sclk   [2];
  logic        sdi    [2];
  logic [1:0]  sync_n [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      ad5674_spi_drv #(
        .CLK_DIV (gi == 0 ? 4 : 1),
        .CS_SETUP(gi == 0 ? 2 : 1),
        .CS_HOLD (gi == 0 ? 2 : 1),
        .CS_GAP  (gi == 0 ? 4 : 1)
      ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ad5674_trig  (trig[gi]),
        .ad5674_cmd   (cmd[gi]),
        .ad5674_ch    (ch[gi]),
        .ad5674_din   (din[gi]),
        .ad5674_busy  (busy[gi]),
        .ad5674_done  (done[gi]),
        .ad5674_drop  (drop[gi]),
        .ad5674_sclk  (sclk[gi]),
        .ad5674_sdi   (sdi[gi]),
        .ad5674_sync_n(sync_n[gi])
      );
    end
  endgenerate

  function automatic int p_cd(input int i);  return (i == 0) ? 4 : 1; endfunction
  function automatic int p_su(input int i);  return (i == 0) ? 2 : 1; endfunction
  function automatic int p_ho(input int i);  return (i == 0) ? 2 : 1; endfunction
  function automatic int p_gp(input int i);  return (i == 0) ? 4 : 1; endfunction
  function automatic int p_t(input int i);
    return p_su(i) + 48 * p_cd(i) + p_ho(i) + p_gp(i);
  endfunction

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Model state: k_acc is the frame origin so that offset 1 is the first busy cycle.
  logic        act      [2] = '{1'b0, 1'b0};
  int          k_acc    [2] = '{0, 0};
  logic [23:0] frm      [2] = '{24'h0, 24'h0};
  logic        sel      [2] = '{1'b0, 1'b0};
  int          done_due [2] = '{-1, -1};
  int          done_prv [2] = '{-1, -1};
  int          drop_due [2] = '{-1, -1};

  // Monitors
  logic        prev_sclk [2] = '{1'b1, 1'b1};
  int          falls     [2] = '{0, 0};
  logic [23:0] cap       [2] = '{24'h0, 24'h0};
  int          low0      [2] = '{0, 0};
  int          low1      [2] = '{0, 0};
  int          donecnt   [2] = '{0, 0};
  int          dropcnt   [2] = '{0, 0};
  int          gapcnt    [2] = '{0, 0};

  task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s inst%0d cyc%0d: got %0h expected %0h", nm, i, cyc, got, exp);
    end
  endtask

  // Model update on each rising edge from the sampled trigger and reset.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (!rst_n) begin
          act[i]      = 1'b0;
          done_due[i] = -1;
          done_prv[i] = -1;
          drop_due[i] = -1;
        end else if (trig[i]) begin
          if (act[i] && (cyc - 1 - k_acc[i]) >= 1 && (cyc - 1 - k_acc[i]) <= p_t(i)) begin
            drop_due[i] = cyc;
          end else begin
            act[i]      = 1'b1;
            k_acc[i]    = cyc - 1;
            frm[i]      = {cmd[i], ch[i][3:0], din[i]};
            sel[i]      = ch[i][4];
            done_prv[i] = done_due[i];
            done_due[i] = cyc + p_t(i);
          end
        end
      end
    end
  end

  // Compare process: every cycle, every output of both instances.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        int off, s, cd;
        logic insync, inshift, inb, esclk;
        logic [1:0] es;
        logic [23:0] f;
        if (prev_sclk[i] && !sclk[i]) begin
          falls[i]++;
          cap[i] = {cap[i][22:0], sdi[i]};
        end
        prev_sclk[i] = sclk[i];
        if (!sync_n[i][0]) low0[i]++;
        if (!sync_n[i][1]) low1[i]++;
        if (done[i]) donecnt[i]++;
        if (drop[i]) dropcnt[i]++;
        if (busy[i] && sync_n[i] == 2'b11) gapcnt[i]++;

        if (!rst_n) begin
          chk("rst_busy", i, busy[i], 0);
          chk("rst_sclk", i, sclk[i], 1);
          chk("rst_sync", i, sync_n[i], 2'b11);
          chk("rst_done", i, done[i], 0);
          chk("rst_drop", i, drop[i], 0);
          chk("rst_sdi", i, sdi[i], 0);
        end else begin
          cd      = p_cd(i);
          off     = cyc - k_acc[i];
          s       = off - 1 - p_su(i);
          inb     = act[i] && off >= 1 && off <= p_t(i);
          insync  = act[i] && off >= 1 && off <= p_t(i) - p_gp(i);
          inshift = act[i] && s >= 0 && s < 48 * cd;
          es      = insync ? (sel[i] ? 2'b01 : 2'b10) : 2'b11;
          esclk   = inshift ? (((s / cd) % 2) == 0) : 1'b1;
          f       = frm[i];
          chk("busy", i, busy[i], inb);
          chk("sync_n", i, sync_n[i], es);
          chk("sclk", i, sclk[i], esclk);
          chk("done", i, done[i], (cyc == done_due[i]) || (cyc == done_prv[i]));
          chk("drop", i, drop[i], cyc == drop_due[i]);
          if (inshift)
            chk("sdi", i, sdi[i], f[23 - s / (2 * cd)]);
          else if (insync && s >= 48 * cd)
            chk("sdi_hold", i, sdi[i], f[0]);
          else if (!inb)
            chk("sdi_idle", i, sdi[i], 0);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Drive a one-cycle trigger; k is the edge that samples it.
  task automatic send(input int i, input logic [3:0] c, input logic [4:0] h,
                      input logic [15:0] d, output int k);
    trig[i] = 1'b1;
    cmd[i]  = c;
    ch[i]   = h;
    din[i]  = d;
    k = cyc + 1;
    tick();
    trig[i] = 1'b0;
    cmd[i]  = ~c;
    ch[i]   = ~h;
    din[i]  = ~d;
  endtask

  task automatic wait_done(input int i, input int lim, output int at);
    at = -1;
    for (int n = 0; n < lim; n++) begin
      tick();
      if (done[i] === 1'b1) begin
        at = cyc;
        break;
      end
    end
    chk("done_seen", i, at >= 0, 1);
  endtask

  task automatic do_frame(input int i, input logic [3:0] c, input logic [4:0] h,
                          input logic [15:0] d, input logic [23:0] exp_frm,
                          input int exp_low, input int exp_t);
    int k, at, f0, l0, l1;
    f0 = falls[i];
    l0 = low0[i];
    l1 = low1[i];
    send(i, c, h, d, k);
    chk("sync_fall", i, sync_n[i][h[4]], 0);
    wait_done(i, 400, at);
    $display("[TB] inst%0d frame cmd=%0h ch=%0h din=%0h sampled=%06h done_after=%0d",
             i, c, h, d, cap[i], at - k);
    chk("done_time", i, at - k, exp_t);
    chk("falls", i, falls[i] - f0, 24);
    chk("frame", i, cap[i], exp_frm);
    chk("sync_sel_low", i, h[4] ? (low1[i] - l1) : (low0[i] - l0), exp_low);
    chk("sync_other_low", i, h[4] ? (low0[i] - l0) : (low1[i] - l1), 0);
  endtask

  initial begin
    int k, at, d0, p0, g0;
    for (int i = 0; i < 2; i++) begin
      trig[i] = 1'b0;
      cmd[i]  = '0;
      ch[i]   = '0;
      din[i]  = '0;
    end
    tick();
    tick();
    chk("reset_busy", 0, busy[0], 0);
    chk("reset_sclk", 0, sclk[0], 1);
    chk("reset_sync", 0, sync_n[0], 2'b11);
    chk("reset_sdi", 0, sdi[0], 0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Single write, defaults
    do_frame(0, 4'h3, 5'h07, 16'hABCD, 24'h37ABCD, 196, 200);
    repeat (5) tick();

    // Device select
    do_frame(0, 4'h3, 5'h1F, 16'hFFF0, 24'h3FFFF0, 196, 200);
    repeat (5) tick();

    // Back-to-back: second trigger in the done cycle
    g0 = gapcnt[0];
    p0 = dropcnt[0];
    do_frame(0, 4'h3, 5'h07, 16'h8000, 24'h378000, 196, 200);
    do_frame(0, 4'h3, 5'h07, 16'h0001, 24'h370001, 196, 200);
    chk("b2b_gap", 0, gapcnt[0] - g0, 8);
    chk("b2b_nodrop", 0, dropcnt[0] - p0, 0);
    $display("[TB] back-to-back gap_cycles=%0d drops=%0d", gapcnt[0] - g0, dropcnt[0] - p0);
    repeat (5) tick();

    // Trigger during an active frame
    d0 = donecnt[0];
    p0 = dropcnt[0];
    send(0, 4'h2, 5'h05, 16'h5A5A, k);
    while (cyc < k + 49) tick();
    trig[0] = 1'b1;
    cmd[0]  = 4'hF;
    ch[0]   = 5'h1F;
    din[0]  = 16'h0000;
    tick();
    trig[0] = 1'b0;
    chk("drop_pulse", 0, drop[0], 1);
    wait_done(0, 400, at);
    chk("drop_done_time", 0, at - k, 200);
    chk("drop_frame", 0, cap[0], 24'h255A5A);
    tick();
    chk("drop_one_done", 0, donecnt[0] - d0, 1);
    chk("drop_count", 0, dropcnt[0] - p0, 1);
    $display("[TB] drop test sampled=%06h dones=%0d drops=%0d", cap[0], donecnt[0] - d0, dropcnt[0] - p0);
    repeat (5) tick();

    // Reset mid-SHIFT (bit 12)
    d0 = donecnt[0];
    send(0, 4'h3, 5'h07, 16'hABCD, k);
    while (cyc < k + 94) tick();
    chk("pre_reset_sclk", 0, sclk[0], 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_sclk", 0, sclk[0], 1);
    chk("async_rst_sync", 0, sync_n[0], 2'b11);
    chk("async_rst_busy", 0, busy[0], 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (220) tick();
    chk("rst_no_done", 0, donecnt[0] - d0, 0);
    $display("[TB] reset mid-frame dones_after=%0d", donecnt[0] - d0);
    do_frame(0, 4'h3, 5'h0C, 16'hC3A5, 24'h3CC3A5, 196, 200);
    repeat (5) tick();

    // Minimal timing parameterization
    do_frame(1, 4'h2, 5'h0A, 16'h1234, 24'h2A1234, 50, 51);
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
